// File: rtl/pbdebounce_pkg.sv
// Shared constants and width helper for the multi-channel debouncer.
package pbdebounce_pkg;

    localparam int DEF_STABLE_CNT = 8;
    localparam int DEF_REPEAT_DLY = 500;
    localparam int DEF_REPEAT_PER = 100;

    function automatic int clog2_min1(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/pbdebounce_ch.sv
// Single debounce channel: synchroniser, stability counter,
// registered edge pulses and optional auto-repeat.
import pbdebounce_pkg::*;

module pbdebounce_ch #(
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int REPEAT_DLY = DEF_REPEAT_DLY,
    parameter int REPEAT_PER = DEF_REPEAT_PER
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic rpt
);

    localparam int CNT_W = clog2_min1(STABLE_CNT);
    localparam int MAXV  = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int HW    = clog2_min1(MAXV + 1);

    if (STABLE_CNT < 2) begin : g_err_cnt
        $error("pbdebounce_ch: STABLE_CNT must be >= 2");
    end
    if (REPEAT_DLY > 0 && REPEAT_PER < 1) begin : g_err_per
        $error("pbdebounce_ch: REPEAT_PER must be >= 1");
    end

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             diff;
    logic             flip;

    assign diff = (s2 != level);
    assign flip = tick && diff && (cnt == CNT_W'(STABLE_CNT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            s1            <= btn;
            s2            <= s1;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (tick) begin
                if (!diff) begin
                    cnt <= '0;
                end else if (flip) begin
                    level         <= s2;
                    cnt           <= '0;
                    press         <= s2;
                    release_pulse <= !s2;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    if (REPEAT_DLY > 0) begin : g_rpt
        logic [HW-1:0] hold;
        logic          rep;
        logic [HW-1:0] tgt;

        // hold restarts from zero after each pulse; the target switches
        // from the initial delay to the repeat period once repeating
        assign tgt = rep ? HW'(REPEAT_PER - 1) : HW'(REPEAT_DLY - 1);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hold <= '0;
                rep  <= 1'b0;
                rpt  <= 1'b0;
            end else begin
                rpt <= 1'b0;
                if (!level || flip) begin
                    hold <= '0;
                    rep  <= 1'b0;
                end else if (tick) begin
                    if (hold == tgt) begin
                        rpt  <= 1'b1;
                        hold <= '0;
                        rep  <= 1'b1;
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
            end
        end
    end else begin : g_norpt
        assign rpt = 1'b0;
    end

endmodule

// File: rtl/pbdebounce_multi.sv
// Multi-channel push-button debouncer: N_CH independent channels
// sharing clock, reset and sample tick.
import pbdebounce_pkg::*;

module pbdebounce_multi #(
    parameter int N_CH       = 4,
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int REPEAT_DLY = DEF_REPEAT_DLY,
    parameter int REPEAT_PER = DEF_REPEAT_PER
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] rpt
);

    if (N_CH < 1 || N_CH > 32) begin : g_err_nch
        $error("pbdebounce_multi: N_CH must be in 1..32");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pbdebounce_ch #(
            .STABLE_CNT(STABLE_CNT),
            .REPEAT_DLY(REPEAT_DLY),
            .REPEAT_PER(REPEAT_PER)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .tick         (tick),
            .btn          (btn[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .rpt          (rpt[i])
        );
    end

endmodule
